uart_rx_buffered: RTL and testbench

- Standalone 8N1 UART receiver with a byte FIFO. It is the receive-side counterpart to the rvx UART transmit line on board tops.
- Board tops use it to take host input at the pin, such as commands from the Cmod A7 USB-UART bridge.
- It presents received bytes on a valid/ready stream and flags framing errors and overflow.
- Single clock domain. The `uart_rx` pin is asynchronous and is synchronized internally.

---
 rtl/uart_rx_buffered.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffered.sv
// rtl/uart_rx_buffered.sv - 8N1 UART receiver with first-word fall-through byte FIFO
// Framing errors and FIFO overflow are reported as single-cycle pulses.
module uart_rx_buffered #(
    parameter int CLOCK_FREQUENCY_HZ = 12000000,
    parameter int BAUD_RATE          = 9600,
    parameter int FIFO_DEPTH         = 8
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 uart_rx,
    output logic [7:0]                           rx_data,
    output logic                                 rx_valid,
    input  logic                                 rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
    output logic                                 framing_error,
    output logic                                 overflow,
    output logic                                 busy
);

    localparam int CYCLES_PER_BIT = CLOCK_FREQUENCY_HZ / BAUD_RATE;
    localparam int CNT_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int PTR_W          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int COUNT_W        = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   CNT_HALF = CNT_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(FIFO_DEPTH);

    if (CYCLES_PER_BIT < 4) begin : g_bad_baud
        $error("uart_rx_buffered: CYCLES_PER_BIT must be >= 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_buffered: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic             rx_meta_q;
    logic             rx_s_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             push_q;
    logic [7:0]       push_data_q;
    logic             framing_error_q;
    logic             overflow_q;

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               full;
    logic               pop;
    logic               push_ok;

    // Preset to idle-high so reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            push_q          <= 1'b0;
            push_data_q     <= '0;
            framing_error_q <= 1'b0;
        end else begin
            push_q          <= 1'b0;
            framing_error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= rx_s_q;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            push_q      <= 1'b1;
                            push_data_q <= shift_q;
                            state_q     <= S_IDLE;
                        end else begin
                            framing_error_q <= 1'b1;
                            state_q         <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign full    = (count_q == FULL_CNT);
    assign pop     = rx_valid && rx_ready;
    assign push_ok = push_q && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= push_q && full && !pop;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_q;
        end
    end

    assign rx_valid      = (count_q != '0);
    assign rx_data       = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count    = count_q;
    assign framing_error = framing_error_q;
    assign overflow      = overflow_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb/tb_uart_rx_buffered.sv - directed self-checking bench for uart_rx_buffered
module tb_uart_rx_buffered;

    logic       clock = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [3:0] fifo_count;
    logic       framing_error;
    logic       overflow;
    logic       busy;

    int         checks   = 0;
    int         failures = 0;
    int         fe_cnt   = 0;
    int         ov_cnt   = 0;
    int         max_cnt  = 0;
    bit         busy_seen = 1'b0;
    logic [7:0] pop_log [$];

    uart_rx_buffered #(
        .CLOCK_FREQUENCY_HZ(1600000),
        .BAUD_RATE         (100000),
        .FIFO_DEPTH        (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .uart_rx      (uart_rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .fifo_count   (fifo_count),
        .framing_error(framing_error),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // A pop is logged before the edge where the DUT will see it.
    task automatic tick();
        if (rx_valid === 1'b1 && rx_ready === 1'b1) pop_log.push_back(rx_data);
        @(posedge clock);
        #1;
        if (framing_error === 1'b1) fe_cnt++;
        if (overflow === 1'b1) ov_cnt++;
        if (busy === 1'b1) busy_seen = 1'b1;
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    endtask

    // Stop-bit tick 11 lines up with the push edge (start-bit drive + 156 edges).
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit pop_at_push);
        uart_rx = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (16) tick();
        end
        uart_rx = stop_bit;
        for (int j = 0; j < 16; j++) begin
            if (pop_at_push) rx_ready = (j == 11);
            tick();
        end
        if (pop_at_push) rx_ready = 1'b0;
        uart_rx = 1'b1;
    endtask

    initial begin
        int fe0, ov0, p0;

        reset    = 1'b1;
        uart_rx  = 1'b1;
        rx_ready = 1'b0;
        repeat (3) tick();
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_fifo_count", fifo_count, 4'd0);
        check("reset_framing_error", framing_error, 1'b0);
        check("reset_overflow", overflow, 1'b0);
        check("reset_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (4) tick();

        // Two bytes streamed straight through
        fe0 = fe_cnt; ov0 = ov_cnt; p0 = pop_log.size(); max_cnt = 0;
        rx_ready = 1'b1;
        send_frame(8'h55, 1'b1, 1'b0);
        repeat (4) tick();
        send_frame(8'hA3, 1'b1, 1'b0);
        repeat (4) tick();
        check("stream_pop_count", pop_log.size() - p0, 2);
        if (pop_log.size() >= p0 + 2) begin
            check("stream_byte0", pop_log[p0], 8'h55);
            check("stream_byte1", pop_log[p0+1], 8'hA3);
        end
        check("stream_max_count", max_cnt, 1);
        check("stream_no_fe", fe_cnt - fe0, 0);
        check("stream_no_ov", ov_cnt - ov0, 0);

        // Short low glitch
        fe0 = fe_cnt; ov0 = ov_cnt; p0 = pop_log.size(); busy_seen = 1'b0;
        uart_rx = 1'b0;
        repeat (4) tick();
        uart_rx = 1'b1;
        repeat (20) tick();
        check("glitch_busy_seen", busy_seen, 1'b1);
        check("glitch_busy_idle", busy, 1'b0);
        check("glitch_no_push", pop_log.size() - p0, 0);
        check("glitch_count", fifo_count, 4'd0);
        check("glitch_no_fe", fe_cnt - fe0, 0);
        check("glitch_no_ov", ov_cnt - ov0, 0);

        // Bad stop bit, held break, then a good byte
        fe0 = fe_cnt; ov0 = ov_cnt; p0 = pop_log.size();
        send_frame(8'h00, 1'b0, 1'b0);
        uart_rx = 1'b0;
        repeat (40) tick();
        uart_rx = 1'b1;
        repeat (8) tick();
        check("break_fe_once", fe_cnt - fe0, 1);
        check("break_no_push", pop_log.size() - p0, 0);
        send_frame(8'h7E, 1'b1, 1'b0);
        repeat (4) tick();
        check("break_next_count", pop_log.size() - p0, 1);
        if (pop_log.size() >= p0 + 1) check("break_next_byte", pop_log[p0], 8'h7E);
        check("break_no_ov", ov_cnt - ov0, 0);

        // Fill the FIFO and overflow on the ninth byte
        rx_ready = 1'b0;
        ov0 = ov_cnt; fe0 = fe_cnt;
        for (int k = 1; k <= 8; k++) begin
            send_frame(8'(k), 1'b1, 1'b0);
            repeat (2) tick();
        end
        check("fill_count8", fifo_count, 4'd8);
        check("fill_no_ov_yet", ov_cnt - ov0, 0);
        send_frame(8'h09, 1'b1, 1'b0);
        repeat (2) tick();
        check("fill_ov_once", ov_cnt - ov0, 1);
        check("fill_count_held", fifo_count, 4'd8);
        p0 = pop_log.size();
        rx_ready = 1'b1;
        repeat (12) tick();
        rx_ready = 1'b0;
        check("drain_pop_count", pop_log.size() - p0, 8);
        if (pop_log.size() >= p0 + 8) begin
            for (int k = 0; k < 8; k++) check($sformatf("drain_byte%0d", k), pop_log[p0+k], 8'(k + 1));
        end
        check("drain_count0", fifo_count, 4'd0);
        check("fill_no_fe", fe_cnt - fe0, 0);

        // Full FIFO with a pop on the push edge
        for (int k = 0; k < 8; k++) begin
            send_frame(8'h10 + 8'(k), 1'b1, 1'b0);
            repeat (2) tick();
        end
        check("full2_count8", fifo_count, 4'd8);
        ov0 = ov_cnt; p0 = pop_log.size();
        send_frame(8'hC4, 1'b1, 1'b1);
        repeat (2) tick();
        check("simul_no_ov", ov_cnt - ov0, 0);
        check("simul_count8", fifo_count, 4'd8);
        check("simul_one_pop", pop_log.size() - p0, 1);
        rx_ready = 1'b1;
        repeat (12) tick();
        rx_ready = 1'b0;
        check("simul_total_pops", pop_log.size() - p0, 9);
        if (pop_log.size() >= p0 + 9) begin
            check("simul_first", pop_log[p0], 8'h10);
            check("simul_eighth", pop_log[p0+7], 8'h17);
            check("simul_last", pop_log[p0+8], 8'hC4);
        end

        // Reset in the middle of a data bit with bytes queued
        send_frame(8'hAA, 1'b1, 1'b0);
        repeat (2) tick();
        send_frame(8'hBB, 1'b1, 1'b0);
        repeat (2) tick();
        check("midreset_queued", fifo_count, 4'd2);
        uart_rx = 1'b0;
        repeat (16) tick();
        repeat (48) tick();
        check("midreset_busy_before", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        uart_rx = 1'b1;
        check("midreset_rx_data", rx_data, 8'h00);
        check("midreset_rx_valid", rx_valid, 1'b0);
        check("midreset_count", fifo_count, 4'd0);
        check("midreset_busy", busy, 1'b0);
        check("midreset_fe", framing_error, 1'b0);
        check("midreset_ov", overflow, 1'b0);
        repeat (20) tick();
        p0 = pop_log.size();
        rx_ready = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b0);
        repeat (4) tick();
        check("post_reset_pops", pop_log.size() - p0, 1);
        if (pop_log.size() >= p0 + 1) check("post_reset_byte", pop_log[p0], 8'h3C);
        check("post_reset_count", fifo_count, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
